mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between the data cache (port 0) and the instruction cache (port 1).
- Each cache requests a whole-line transfer: a writeback (write) or a refill (read).
- The arbiter grants one port at a time and sequences the line word by word against a fixed-latency memory.
- It reports the current word index, the read data, and a completion pulse back to the granted cache.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_rr_arb2.sv | 31 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory port arbiter.
// The line-address width helper keeps port widths consistent across files.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam int PORT_D = 0;
   localparam int PORT_I = 1;

   function automatic int line_w(input int addr_w, input int line_addr_len);
      return addr_w - line_addr_len - 2;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin pick. The pointer remembers the last owner, so on
// contention the other port wins; after reset the data cache is favoured.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       owner,
   output logic       pick
);

   logic last_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_reg <= 1'(PORT_I);
      else if (update)
         last_reg <= owner;
   end

   always_comb begin
      pick = 1'(PORT_D);
      if (req == 2'b10)
         pick = 1'(PORT_I);
      else if (req == 2'b11)
         pick = ~last_reg;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to the data or instruction cache and walks the
// owner's line one word at a time against a fixed-latency memory.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LINE_ADDR_LEN = 3,
   parameter int ADDR_W        = 32,
   parameter int MEM_LAT       = 4
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [1:0]                                   req,
   input  logic [1:0]                                   wr,
   input  logic [line_w(ADDR_W, LINE_ADDR_LEN)-1:0]     line_addr0,
   input  logic [line_w(ADDR_W, LINE_ADDR_LEN)-1:0]     line_addr1,
   input  logic [31:0]                                  wdata0,
   input  logic [31:0]                                  wdata1,
   output logic [1:0]                                   gnt,
   output logic [LINE_ADDR_LEN-1:0]                     word_idx,
   output logic [31:0]                                  rdata,
   output logic                                         rvalid,
   output logic [1:0]                                   done,
   output logic [ADDR_W-1:0]                            mem_addr,
   output logic [31:0]                                  mem_wdata,
   output logic                                         mem_we,
   output logic                                         mem_re,
   input  logic [31:0]                                  mem_rdata
);

   localparam int LW = line_w(ADDR_W, LINE_ADDR_LEN);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0]            LAST_CNT  = CW'(MEM_LAT - 1);
   localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;

   state_t                   state_reg, state_next;
   logic                     owner_reg, owner_next;
   logic                     wr_reg, wr_next;
   logic [LW-1:0]            line_reg, line_next;
   logic [LINE_ADDR_LEN-1:0] idx_reg, idx_next;
   logic [CW-1:0]            cnt_reg, cnt_next;
   logic [31:0]              rdata_reg, rdata_next;
   logic                     pick;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .update (state_reg == DONE),
      .owner  (owner_reg),
      .pick   (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         wr_reg    <= 1'b0;
         line_reg  <= '0;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         wr_reg    <= wr_next;
         line_reg  <= line_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         rdata_reg <= rdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      wr_next    = wr_reg;
      line_next  = line_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      rdata_next = rdata_reg;
      gnt        = (state_reg != IDLE) ? (2'b01 << owner_reg) : 2'b00;
      done       = 2'b00;
      rvalid     = 1'b0;
      rdata      = rdata_reg;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_wdata  = '0;
      case (state_reg)
         IDLE: begin
            if (req != 2'b00) begin
               owner_next = pick;
               wr_next    = wr[pick];
               line_next  = (pick == 1'(PORT_I)) ? line_addr1 : line_addr0;
               idx_next   = '0;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_reg) begin
               mem_we    = 1'b1;
               mem_wdata = (owner_reg == 1'(PORT_I)) ? wdata1 : wdata0;
            end else begin
               mem_re = 1'b1;
            end
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == LAST_CNT) begin
               // Read data is forwarded in the cycle it arrives and held afterwards.
               if (!wr_reg) begin
                  rvalid     = 1'b1;
                  rdata      = mem_rdata;
                  rdata_next = mem_rdata;
               end
               if (idx_reg == LAST_WORD) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx_reg + LINE_ADDR_LEN'(1);
                  state_next = ISSUE;
               end
            end
         end
         DONE: begin
            done       = gnt;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign word_idx = idx_reg;
   assign mem_addr = {line_reg, idx_reg, 2'b00};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=4 instance for the main
// scenarios and a MEM_LAT=1 instance for the short-latency build.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int LAT = 4;
   localparam int LAL = 3;
   localparam int AW  = 32;
   localparam int LW  = AW - LAL - 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req = 2'b00;
   logic [1:0]    wr  = 2'b00;
   logic [LW-1:0] line_addr0 = '0;
   logic [LW-1:0] line_addr1 = '0;
   logic [31:0]   wdata0, wdata1;
   logic [1:0]    gnt, done;
   logic [LAL-1:0] word_idx;
   logic [31:0]   rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic          rvalid, mem_we, mem_re;

   logic [1:0]    b_req = 2'b00;
   logic [LW-1:0] b_line = '0;
   logic [1:0]    b_gnt, b_done;
   logic [LAL-1:0] b_word_idx;
   logic [31:0]   b_rdata, b_mem_wdata, b_mem_rdata;
   logic [AW-1:0] b_mem_addr;
   logic          b_rvalid, b_mem_we, b_mem_re;

   int checks = 0;
   int errors = 0;
   int overlap = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr),
      .line_addr0(line_addr0), .line_addr1(line_addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .word_idx(word_idx), .rdata(rdata), .rvalid(rvalid), .done(done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req(b_req), .wr(2'b00),
      .line_addr0(b_line), .line_addr1(b_line),
      .wdata0(32'h0), .wdata1(32'h0),
      .gnt(b_gnt), .word_idx(b_word_idx), .rdata(b_rdata), .rvalid(b_rvalid), .done(b_done),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
      .mem_rdata(b_mem_rdata)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] exp_addr(input logic [LW-1:0] l, input int w);
      return {l, 3'(w), 2'b00};
   endfunction

   // Caches present the word selected by word_idx combinationally.
   always_comb begin
      wdata0 = 32'h5A5A0000 + 32'(word_idx);
      wdata1 = 32'hA5A50000 + 32'(word_idx);
   end

   // Fixed-latency memory models: data valid LAT cycles after the mem_re cycle.
   logic [31:0] pipe_a [LAT];
   logic        pipe_v [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_a[i] <= '0;
         end
      end else begin
         pipe_v[0] <= mem_re;
         pipe_a[0] <= mem_addr;
         for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
      end
   end
   assign mem_rdata = pipe_v[LAT-1] ? mem_fn(pipe_a[LAT-1]) : 32'hDEADBEEF;

   logic        b_pv;
   logic [31:0] b_pa;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         b_pv <= 1'b0;
         b_pa <= '0;
      end else begin
         b_pv <= b_mem_re;
         b_pa <= b_mem_addr;
      end
   end
   assign b_mem_rdata = b_pv ? mem_fn(b_pa) : 32'hDEADBEEF;

   always @(negedge clk) begin
      if (mem_we && mem_re) overlap++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({gnt, done, rvalid, mem_we, mem_re} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0", {gnt, done, rvalid, mem_we, mem_re});
      end
      checks++;
      if (word_idx !== 3'd0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: word_idx %0d rdata %h expected 0 0", word_idx, rdata);
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem: addr %h wdata %h expected 0 0", mem_addr, mem_wdata);
      end
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_refill();
      int cyc = 0;
      int stray = 0;
      logic [31:0] ea;
      line_addr0 = 27'h1234;
      wr  = 2'b00;
      req = 2'b01;
      for (int w = 0; w < 8; w++) begin
         @(negedge clk); cyc++;
         ea = exp_addr(27'h1234, w);
         checks++;
         if (gnt !== 2'b01 || mem_re !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL refill_issue w%0d: gnt %b re %b we %b expected 01 1 0", w, gnt, mem_re, mem_we);
         end
         checks++;
         if (mem_addr !== ea) begin
            errors++;
            $display("FAIL refill_addr w%0d: got %h expected %h", w, mem_addr, ea);
         end
         repeat (LAT - 1) begin
            @(negedge clk); cyc++;
            if (rvalid || mem_re || mem_we) stray++;
         end
         @(negedge clk); cyc++;
         checks++;
         if (rvalid !== 1'b1 || rdata !== mem_fn(ea) || word_idx !== 3'(w)) begin
            errors++;
            $display("FAIL refill_data w%0d: rvalid %b rdata %h idx %0d expected 1 %h %0d",
                     w, rvalid, rdata, word_idx, mem_fn(ea), w);
         end
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL refill_wait_quiet: got %0d stray strobes expected 0", stray);
      end
      @(negedge clk); cyc++;
      checks++;
      if (done !== 2'b01 || gnt !== 2'b01) begin
         errors++;
         $display("FAIL refill_done: done %b gnt %b expected 01 01", done, gnt);
      end
      req = 2'b00;
      @(negedge clk); cyc++;
      checks++;
      if (gnt !== 2'b00 || done !== 2'b00 || cyc !== 42) begin
         errors++;
         $display("FAIL refill_end: gnt %b done %b cycles %0d expected 00 00 42", gnt, done, cyc);
      end
      $display("refill port0 line %h: %0d cycles", 27'h1234, cyc);
   endtask

   task automatic test_writeback();
      int rv = 0;
      logic [31:0] ea;
      line_addr1 = 27'h0ABC;
      wr  = 2'b10;
      req = 2'b10;
      for (int w = 0; w < 8; w++) begin
         @(negedge clk);
         ea = exp_addr(27'h0ABC, w);
         checks++;
         if (gnt !== 2'b10 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== ea) begin
            errors++;
            $display("FAIL wb_issue w%0d: gnt %b we %b re %b addr %h expected 10 1 0 %h",
                     w, gnt, mem_we, mem_re, mem_addr, ea);
         end
         checks++;
         if (mem_wdata !== 32'hA5A50000 + 32'(w)) begin
            errors++;
            $display("FAIL wb_wdata w%0d: got %h expected %h", w, mem_wdata, 32'hA5A50000 + 32'(w));
         end
         if (rvalid) rv++;
         repeat (LAT) begin
            @(negedge clk);
            if (rvalid) rv++;
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 2'b10) begin
         errors++;
         $display("FAIL wb_done: got %b expected 10", done);
      end
      checks++;
      if (rv !== 0) begin
         errors++;
         $display("FAIL wb_rvalid: got %0d pulses expected 0", rv);
      end
      req = 2'b00;
      wr  = 2'b00;
      @(negedge clk);
      $display("writeback port1 line %h", 27'h0ABC);
   endtask

   task automatic test_contention();
      logic [1:0] exp_order [3] = '{2'b01, 2'b10, 2'b01};
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      line_addr0 = 27'h10;
      line_addr1 = 27'h20;
      req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         logic [1:0] first = 2'b00;
         logic [1:0] dn = 2'b00;
         for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (first == 2'b00 && gnt != 2'b00) first = gnt;
            if (done != 2'b00) begin
               dn = done;
               break;
            end
         end
         if (k == 2) req = 2'b00;
         checks++;
         if (first !== exp_order[k] || dn !== exp_order[k]) begin
            errors++;
            $display("FAIL contention_grant%0d: gnt %b done %b expected %b", k, first, dn, exp_order[k]);
         end
         $display("contention grant %0d to %b", k, first);
      end
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL contention_idle: got %b expected 00", gnt);
      end
   endtask

   task automatic test_req_drop();
      int nre = 0;
      logic seen = 1'b0;
      int late = 0;
      line_addr0 = 27'h0077;
      wr  = 2'b00;
      req = 2'b01;
      for (int t = 0; t < 80; t++) begin
         @(negedge clk);
         if (mem_re) begin
            nre++;
            if (word_idx == 3'd3) req = 2'b00;
         end
         if (done == 2'b01) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (nre !== 8 || seen !== 1'b1) begin
         errors++;
         $display("FAIL req_drop: reads %0d done %b expected 8 1", nre, seen);
      end
      repeat (4) begin
         @(negedge clk);
         if (gnt != 2'b00) late++;
      end
      checks++;
      if (late !== 0) begin
         errors++;
         $display("FAIL req_drop_regrant: got %0d granted cycles expected 0", late);
      end
      $display("request drop refill port0: %0d reads", nre);
   endtask

   task automatic test_reset_mid();
      logic found = 1'b0;
      int bad = 0;
      logic [1:0] dn = 2'b00;
      line_addr0 = 27'h0055;
      wr  = 2'b00;
      req = 2'b01;
      for (int t = 0; t < 80; t++) begin
         @(negedge clk);
         if (mem_re && word_idx == 3'd5) begin
            found = 1'b1;
            break;
         end
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (found !== 1'b1 || {gnt, done, rvalid, mem_we, mem_re} !== 7'b0 || word_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid_async: found %b ctrl %b idx %0d expected 1 0 0",
                  found, {gnt, done, rvalid, mem_we, mem_re}, word_idx);
      end
      @(negedge clk);
      checks++;
      if ({gnt, done, mem_we, mem_re} !== 6'b0 || word_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid_held: ctrl %b idx %0d expected 0 0", {gnt, done, mem_we, mem_re}, word_idx);
      end
      rst = 1'b0;
      req = 2'b00;
      repeat (10) begin
         @(negedge clk);
         if (done != 2'b00 || gnt != 2'b00) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_mid_nodone: got %0d active cycles expected 0", bad);
      end
      req = 2'b11;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL reset_mid_regrant: got %b expected 01", gnt);
      end
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (done != 2'b00) begin
            dn = done;
            break;
         end
      end
      req = 2'b00;
      checks++;
      if (dn !== 2'b01) begin
         errors++;
         $display("FAIL reset_mid_finish: got %b expected 01", dn);
      end
      @(negedge clk);
      $display("reset mid-transfer then regrant port0");
   endtask

   task automatic test_lat1();
      int cyc = 0;
      logic [31:0] ea;
      b_line = 27'h0042;
      b_req  = 2'b01;
      for (int w = 0; w < 8; w++) begin
         ea = exp_addr(27'h0042, w);
         @(negedge clk); cyc++;
         checks++;
         if (b_mem_re !== 1'b1 || b_mem_addr !== ea || b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL lat1_issue w%0d: re %b addr %h rvalid %b expected 1 %h 0",
                     w, b_mem_re, b_mem_addr, b_rvalid, ea);
         end
         @(negedge clk); cyc++;
         checks++;
         if (b_rvalid !== 1'b1 || b_rdata !== mem_fn(ea) || b_word_idx !== 3'(w)) begin
            errors++;
            $display("FAIL lat1_data w%0d: rvalid %b rdata %h idx %0d expected 1 %h %0d",
                     w, b_rvalid, b_rdata, b_word_idx, mem_fn(ea), w);
         end
      end
      @(negedge clk); cyc++;
      checks++;
      if (b_done !== 2'b01) begin
         errors++;
         $display("FAIL lat1_done: got %b expected 01", b_done);
      end
      b_req = 2'b00;
      @(negedge clk); cyc++;
      checks++;
      if (b_gnt !== 2'b00 || cyc !== 18) begin
         errors++;
         $display("FAIL lat1_end: gnt %b cycles %0d expected 00 18", b_gnt, cyc);
      end
      $display("refill MEM_LAT=1 line %h: %0d cycles", 27'h0042, cyc);
   endtask

   initial begin
      test_reset();
      test_refill();
      test_writeback();
      test_contention();
      test_req_drop();
      test_reset_mid();
      test_lat1();
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", overlap);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
